match_ctrl: RTL and testbench

- Parametrised N-player match controller. It succeeds the fixed 2-player game FSM used by the tank game top level.
- Owns the menu/playing/continue/final flow, per-player scores, the selectable win target, the winner and draw result, and the round-reset strobe to gameplay blocks.
- Sits between the player/bullet logic (score events in) and the renderer and score display (state flags and scores out).
- All timing is in video frames, paced by a frame tick from the sync generator.

---
 rtl/match_ctrl.sv | 174 +++++++++++++++++
 tb/tb_match_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// N-player match controller: menu, rounds, continue hold, final result.
// Optional MATCH_PAUSE_EN adds a PAUSED state and a paused_o output.
module match_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_BITS  = 6,
    parameter int WIN_SCORE   = 3,
    parameter int MENU_ITEMS  = 3,
    parameter int HOLD_FRAMES = 2,
    localparam int SEL_W = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1,
    localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              frame_tick_i,
    input  logic                              start_i,
    input  logic                              sel_up_i,
    input  logic                              sel_down_i,
    input  logic [NUM_PLAYERS-1:0]            score_evt_i,
    output logic [NUM_PLAYERS*SCORE_BITS-1:0] score_o,
    output logic [SEL_W-1:0]                  menu_sel_o,
    output logic                              is_menu_o,
    output logic                              is_playing_o,
    output logic                              is_continue_o,
    output logic                              is_final_o,
    output logic [WIN_W-1:0]                  winner_o,
    output logic                              draw_o,
    output logic                              round_reset_o
`ifdef MATCH_PAUSE_EN
    ,
    output logic                              paused_o
`endif
);

    localparam int TW     = SCORE_BITS + 2;
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(MENU_ITEMS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    // Targets above the saturated score could never be reached.
    if (MENU_ITEMS * WIN_SCORE > 2 ** SCORE_BITS - 1) begin : g_bad_target
        $error("match_ctrl: win target exceeds score saturation");
    end

    typedef enum logic [2:0] {
        S_MENU, S_PLAY, S_CONT, S_FINAL, S_PAUSE
    } state_t;

    state_t                  state, next;
    logic                    start_q, up_q, down_q;
    logic [NUM_PLAYERS-1:0]  evt_q, evt_e;
    logic                    start_e, up_e, down_e, hit;
    logic [SCORE_BITS-1:0]   score [NUM_PLAYERS];
    logic [SEL_W-1:0]        sel;
    logic [TW-1:0]           target, target_sel;
    logic [HOLD_W-1:0]       hold;
    logic                    hold_done, reached, resume, tie;
    logic [SCORE_BITS-1:0]   best;
    logic [WIN_W-1:0]        best_idx;

    assign start_e    = start_i & ~start_q;
    assign up_e       = sel_up_i & ~up_q;
    assign down_e     = sel_down_i & ~down_q;
    assign evt_e      = score_evt_i & ~evt_q;
    assign hit        = |evt_e;
    assign hold_done  = (hold == HOLD_MAX);
    assign target_sel = (TW'(sel) + TW'(1)) * TW'(WIN_SCORE);

    always_comb begin
        reached = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++)
            if ({2'b00, score[k]} >= target) reached = 1'b1;
    end

    // Lowest index wins ties; tie flags any other player on the max.
    always_comb begin
        best     = score[0];
        best_idx = '0;
        tie      = 1'b0;
        for (int k = 1; k < NUM_PLAYERS; k++)
            if (score[k] > best) begin
                best     = score[k];
                best_idx = WIN_W'(k);
            end
        for (int k = 0; k < NUM_PLAYERS; k++)
            if (score[k] == best && WIN_W'(k) != best_idx) tie = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) state <= S_MENU;
        else           state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_MENU:  if (start_e) next = S_PLAY;
            S_PLAY: begin
                if (hit) next = S_CONT;
`ifdef MATCH_PAUSE_EN
                else if (start_e) next = S_PAUSE;
`endif
            end
            S_CONT:  if (start_e && hold_done)
                         next = reached ? S_FINAL : S_PLAY;
            S_FINAL: if (start_e) next = S_MENU;
            S_PAUSE: if (start_e) next = S_PLAY;
            default: next = S_MENU;
        endcase
    end

    always_comb begin
        is_menu_o     = (state == S_MENU);
        is_playing_o  = (state == S_PLAY);
        is_continue_o = (state == S_CONT);
        is_final_o    = (state == S_FINAL);
        round_reset_o = is_menu_o | is_final_o | resume;
`ifdef MATCH_PAUSE_EN
        paused_o      = (state == S_PAUSE);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            start_q  <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            evt_q    <= '0;
            sel      <= '0;
            target   <= '0;
            hold     <= '0;
            resume   <= 1'b0;
            winner_o <= '0;
            draw_o   <= 1'b0;
            for (int k = 0; k < NUM_PLAYERS; k++) score[k] <= '0;
        end else begin
            start_q <= start_i;
            up_q    <= sel_up_i;
            down_q  <= sel_down_i;
            evt_q   <= score_evt_i;
            resume  <= (state == S_CONT) && (next == S_PLAY);
            if (state == S_MENU) begin
                if (up_e && !down_e && sel != SEL_MAX)
                    sel <= sel + 1'b1;
                else if (down_e && !up_e && sel != '0)
                    sel <= sel - 1'b1;
                if (start_e) begin
                    target <= target_sel;
                    for (int k = 0; k < NUM_PLAYERS; k++) score[k] <= '0;
                end
            end
            if (state == S_PLAY && hit) begin
                hold <= '0;
                for (int k = 0; k < NUM_PLAYERS; k++)
                    if (evt_e[k] && score[k] != '1)
                        score[k] <= score[k] + 1'b1;
            end
            if (state == S_CONT && frame_tick_i && !hold_done)
                hold <= hold + 1'b1;
            if (state == S_CONT && next == S_FINAL) begin
                winner_o <= best_idx;
                draw_o   <= tie;
            end
            if (state == S_FINAL && start_e)
                draw_o <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_score
        assign score_o[k*SCORE_BITS +: SCORE_BITS] = score[k];
    end

    assign menu_sel_o = sel;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl (2 players, base target 3, 3 menu items).
module tb_match_ctrl;

    logic        clk = 1'b0;
    logic        reset_ni, frame_tick, start, sel_up, sel_down;
    logic [1:0]  score_evt;
    logic [11:0] score;
    logic [1:0]  menu_sel;
    logic        is_menu, is_playing, is_continue, is_final;
    logic        winner, draw, round_reset;
    logic [3:0]  flags;
`ifdef MATCH_PAUSE_EN
    logic        paused;
`endif

    always #5 clk = ~clk;

    match_ctrl #(
        .NUM_PLAYERS(2), .SCORE_BITS(6), .WIN_SCORE(3),
        .MENU_ITEMS(3), .HOLD_FRAMES(2)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .frame_tick_i(frame_tick),
        .start_i(start), .sel_up_i(sel_up), .sel_down_i(sel_down),
        .score_evt_i(score_evt), .score_o(score), .menu_sel_o(menu_sel),
        .is_menu_o(is_menu), .is_playing_o(is_playing),
        .is_continue_o(is_continue), .is_final_o(is_final),
        .winner_o(winner), .draw_o(draw), .round_reset_o(round_reset)
`ifdef MATCH_PAUSE_EN
        , .paused_o(paused)
`endif
    );

    assign flags = {is_menu, is_playing, is_continue, is_final};

    localparam logic [3:0] M = 4'b1000, P = 4'b0100, C = 4'b0010, F = 4'b0001;

    typedef struct {
        logic       st, up, dn;
        logic [1:0] evt;
        logic       tick;
        logic [3:0] flags;
        logic [1:0] sel;
        logic [11:0] score;
        logic       rr;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    vec_t tbl[19];

    function automatic vec_t mk(logic s, logic u, logic d, logic [1:0] e,
                                logic t, logic [3:0] f, logic [1:0] sl,
                                logic [11:0] sc, logic r);
        vec_t v;
        v.st = s; v.up = u; v.dn = d; v.evt = e; v.tick = t;
        v.flags = f; v.sel = sl; v.score = sc; v.rr = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [1:0] m);
        score_evt = m; step();
        score_evt = 2'b00; step();
    endtask

    task automatic go();
        frame_tick = 1'b1; step(); step();
        frame_tick = 1'b0;
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    task automatic press();
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,2'b00,0, M,2'd1,12'd0,1);
        tbl[1]  = mk(0,0,0,2'b00,0, M,2'd1,12'd0,1);
        tbl[2]  = mk(0,1,0,2'b00,0, M,2'd2,12'd0,1);
        tbl[3]  = mk(0,0,0,2'b00,0, M,2'd2,12'd0,1);
        tbl[4]  = mk(0,1,0,2'b00,0, M,2'd2,12'd0,1);
        tbl[5]  = mk(0,0,0,2'b00,0, M,2'd2,12'd0,1);
        tbl[6]  = mk(0,0,1,2'b00,0, M,2'd1,12'd0,1);
        tbl[7]  = mk(0,0,0,2'b00,0, M,2'd1,12'd0,1);
        tbl[8]  = mk(0,1,1,2'b00,0, M,2'd1,12'd0,1);
        tbl[9]  = mk(0,0,0,2'b00,0, M,2'd1,12'd0,1);
        tbl[10] = mk(1,0,0,2'b00,0, P,2'd1,12'd0,0);
        tbl[11] = mk(0,0,0,2'b00,0, P,2'd1,12'd0,0);
        tbl[12] = mk(0,0,0,2'b01,0, C,2'd1,12'd1,0);
        tbl[13] = mk(0,0,0,2'b01,0, C,2'd1,12'd1,0);
        tbl[14] = mk(0,0,0,2'b00,1, C,2'd1,12'd1,0);
        tbl[15] = mk(1,0,0,2'b00,0, C,2'd1,12'd1,0);
        tbl[16] = mk(0,0,0,2'b00,1, C,2'd1,12'd1,0);
        tbl[17] = mk(1,0,0,2'b00,0, P,2'd1,12'd1,1);
        tbl[18] = mk(0,0,0,2'b00,0, P,2'd1,12'd1,0);

        reset_ni = 1'b0; frame_tick = 1'b0; start = 1'b0;
        sel_up = 1'b0; sel_down = 1'b0; score_evt = 2'b00;
        step(); step();
        reset_ni = 1'b1;
        chk("reset flags", flags, M);
        chk("reset score", score, 0);
        chk("reset sel", menu_sel, 0);
        chk("reset rr", round_reset, 1);
        chk("reset winner", winner, 0);
        chk("reset draw", draw, 0);

        for (int i = 0; i < 19; i++) begin
            start = tbl[i].st; sel_up = tbl[i].up; sel_down = tbl[i].dn;
            score_evt = tbl[i].evt; frame_tick = tbl[i].tick;
            step();
            chk($sformatf("vec%0d flags", i), flags, tbl[i].flags);
            chk($sformatf("vec%0d sel", i), menu_sel, tbl[i].sel);
            chk($sformatf("vec%0d score", i), score, tbl[i].score);
            chk($sformatf("vec%0d rr", i), round_reset, tbl[i].rr);
        end
        start = 0; sel_up = 0; sel_down = 0; score_evt = 0; frame_tick = 0;

        // Hit held across a continue must score only once.
        score_evt = 2'b01; step();
        chk("held hit state", flags, C);
        chk("held hit score", score, 2);
        frame_tick = 1'b1; step(); step();
        frame_tick = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("held resume state", flags, P);
        repeat (45) step();
        chk("held long state", flags, P);
        chk("held long score", score, 2);
        score_evt = 2'b00; step();

        // Target latched as 6: score 3..5 keeps playing.
        for (int r = 3; r <= 6; r++) begin
            hit(2'b01);
            chk($sformatf("t6 score%0d", r), score, 12'(r));
            go();
            chk($sformatf("t6 state%0d", r), flags, (r < 6) ? P : F);
        end
        chk("t6 winner", winner, 0);
        chk("t6 draw", draw, 0);
        chk("t6 final rr", round_reset, 1);
        press();
        chk("t6 menu", flags, M);
        chk("t6 sel kept", menu_sel, 1);

        sel_down = 1'b1; step(); sel_down = 1'b0; step();
        chk("win sel", menu_sel, 0);
        press();
        chk("win play", flags, P);
        chk("win cleared", score, 0);
        for (int r = 1; r <= 3; r++) begin
            hit(2'b10);
            go();
            chk($sformatf("win state%0d", r), flags, (r < 3) ? P : F);
        end
        chk("win score", score, 12'(3 << 6));
        chk("win winner", winner, 1);
        chk("win draw", draw, 0);
        press();
        chk("win menu", flags, M);
        chk("win winner held", winner, 1);

        press();
        hit(2'b11); go();
        hit(2'b11); go();
        chk("draw 2/2 state", flags, P);
        hit(2'b11);
        chk("draw 3/3 score", score, 12'((3 << 6) | 3));
        chk("draw cont", flags, C);
        go();
        chk("draw final", flags, F);
        chk("draw flag", draw, 1);
        chk("draw winner", winner, 0);
        press();
        chk("draw cleared", draw, 0);

        press();
        hit(2'b01); go();
        hit(2'b01); go();
        chk("midreset pre score", score, 2);
        chk("midreset pre state", flags, P);
        reset_ni = 1'b0; step(); reset_ni = 1'b1;
        chk("midreset state", flags, M);
        chk("midreset score", score, 0);
        chk("midreset rr", round_reset, 1);

`ifdef MATCH_PAUSE_EN
        press();
        press();
        chk("pause flag", paused, 1);
        chk("pause flags", flags, 4'b0000);
        chk("pause rr", round_reset, 0);
        score_evt = 2'b01; step();
        chk("pause hit ignored", score, 0);
        start = 1'b1; step();
        chk("resume state", flags, P);
        chk("resume rr", round_reset, 0);
        start = 1'b0; step();
        chk("resume held hit", score, 0);
        score_evt = 2'b00; step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
